// File: rtl/comm_tx_sched_pkg.sv
// ============================================================================
// comm_tx_sched_pkg : shared types and constants for the comm link TX path
// Revision: 1.0
// ============================================================================
`default_nettype none

package comm_tx_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_PAY  = 2'd2,
      ST_CRC  = 2'd3
   } tx_state_t;

   localparam logic [7:0] PKT_PING    = 8'h00;
   localparam logic [7:0] PKT_PONG    = 8'h01;
   localparam logic [7:0] PKT_ACK     = 8'h02;
   localparam logic [7:0] PKT_RESEND  = 8'h03;
   localparam logic [7:0] PKT_INFO    = 8'h00;
   localparam logic [7:0] PKT_INVALID = 8'h01;

   localparam logic [31:0] CRC32_POLY   = 32'hEDB8_8320;
   localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

   function automatic logic [3:0] clamp_words(input logic [3:0] words,
                                              input logic [3:0] max_words);
      return (words > max_words) ? max_words : words;
   endfunction

endpackage

`default_nettype wire

// File: rtl/crc32_byte.sv
// ============================================================================
// crc32_byte : one reflected IEEE CRC32 update step over a single byte
// Revision: 1.0
// ============================================================================
`default_nettype none

module crc32_byte
   import comm_tx_sched_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  byte_in,
   output logic [31:0] crc_out
);

   logic [31:0] w_crc;

   always_comb begin
      w_crc = crc_in ^ {24'h000000, byte_in};
      for (int i = 0; i < 8; i++) begin
         w_crc = w_crc[0] ? ((w_crc >> 1) ^ CRC32_POLY) : (w_crc >> 1);
      end
   end

   assign crc_out = w_crc;

endmodule

`default_nettype wire

// File: rtl/comm_tx_sched.sv
// ============================================================================
// comm_tx_sched : round-robin packetiser for two requesters onto a byte stream
// Revision: 1.0
// ============================================================================
`default_nettype none

module comm_tx_sched
   import comm_tx_sched_pkg::*;
#(
   parameter int MAX_WORDS = 8,
   parameter bit CRC_EN    = 1'b1
)(
   input  logic                         comm_clk,
   input  logic                         reset,
   input  logic [1:0]                   req_valid,
   output logic [1:0]                   req_ready,
   input  logic [1:0][7:0]              req_type,
   input  logic [1:0][3:0]              req_words,
   input  logic [1:0]                   req_short,
   input  logic [1:0][32*MAX_WORDS-1:0] req_data,
   output logic [7:0]                   tx_data,
   output logic                         tx_valid,
   input  logic                         tx_ready,
   output logic                         busy
);

   localparam int NBYTES = 4 * MAX_WORDS;
   localparam int IW     = $clog2(NBYTES);

   tx_state_t               r_state;
   logic                    r_last;
   logic [7:0]              r_type;
   logic [3:0]              r_words;
   logic                    r_short;
   logic [NBYTES-1:0][7:0]  r_data;
   logic [5:0]              r_cnt;
   logic [31:0]             r_crc;
   logic [7:0]              r_tx_data;
   logic                    r_tx_valid;
   logic [1:0]              r_req_ready;

   logic                    w_gnt;
   logic [3:0]              w_gnt_words;
   logic [7:0]              w_len;
   logic                    w_xfer;
   logic [5:0]              w_cnt_inc;
   logic                    w_pay_last;
   logic [7:0]              w_hdr_next;
   logic [7:0]              w_pay_next;
   logic [31:0]             w_crc_next;
   logic [31:0]             w_crc_out;
   logic [7:0]              w_trl_first;
   logic [7:0]              w_trl_next;

   // On contention the requester not served last wins; alone, a requester always wins
   assign w_gnt       = (req_valid == 2'b11) ? ~r_last : req_valid[1];
   assign w_gnt_words = clamp_words(req_words[w_gnt], 4'(MAX_WORDS));
   assign w_len       = 8'd8 + {2'b00, w_gnt_words, 2'b00};

   assign w_xfer      = r_tx_valid & tx_ready;
   assign w_cnt_inc   = r_cnt + 6'd1;
   assign w_pay_last  = (w_cnt_inc == {r_words, 2'b00});
   assign w_hdr_next  = (w_cnt_inc[1:0] == 2'd3) ? r_type : 8'h00;
   assign w_pay_next  = r_data[w_cnt_inc[IW-1:0]];

   crc32_byte u_crc32_byte (
      .crc_in  (r_crc),
      .byte_in (r_tx_data),
      .crc_out (w_crc_next)
   );

   // The first trailer byte goes out on the same edge that folds in the last data byte
   assign w_crc_out   = r_crc ^ CRC32_XOROUT;
   assign w_trl_first = CRC_EN ? (w_crc_next[7:0] ^ CRC32_XOROUT[7:0]) : 8'h00;
   assign w_trl_next  = CRC_EN ? w_crc_out[{w_cnt_inc[1:0], 3'b000} +: 8] : 8'h00;

   always_ff @(posedge comm_clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_last      <= 1'b1;
         r_type      <= 8'h00;
         r_words     <= 4'd0;
         r_short     <= 1'b0;
         r_data      <= '0;
         r_cnt       <= 6'd0;
         r_crc       <= CRC32_INIT;
         r_tx_data   <= 8'h00;
         r_tx_valid  <= 1'b0;
         r_req_ready <= 2'b00;
      end else begin
         r_req_ready <= 2'b00;
         case (r_state)
            ST_IDLE: begin
               if (|req_valid) begin
                  r_state              <= ST_HDR;
                  r_last               <= w_gnt;
                  r_type               <= req_type[w_gnt];
                  r_words              <= w_gnt_words;
                  r_short              <= req_short[w_gnt];
                  r_data               <= req_data[w_gnt];
                  r_cnt                <= 6'd0;
                  r_crc                <= CRC32_INIT;
                  r_tx_valid           <= 1'b1;
                  r_tx_data            <= req_short[w_gnt] ? req_type[w_gnt] : w_len;
                  r_req_ready[w_gnt]   <= 1'b1;
               end
            end
            ST_HDR: begin
               if (w_xfer) begin
                  r_crc <= w_crc_next;
                  if (r_short) begin
                     r_state    <= ST_IDLE;
                     r_tx_valid <= 1'b0;
                     r_tx_data  <= 8'h00;
                  end else if (r_cnt[1:0] == 2'd3) begin
                     r_cnt <= 6'd0;
                     if (r_words == 4'd0) begin
                        r_state   <= ST_CRC;
                        r_tx_data <= w_trl_first;
                     end else begin
                        r_state   <= ST_PAY;
                        r_tx_data <= r_data[0];
                     end
                  end else begin
                     r_cnt     <= w_cnt_inc;
                     r_tx_data <= w_hdr_next;
                  end
               end
            end
            ST_PAY: begin
               if (w_xfer) begin
                  r_crc <= w_crc_next;
                  if (w_pay_last) begin
                     r_state   <= ST_CRC;
                     r_cnt     <= 6'd0;
                     r_tx_data <= w_trl_first;
                  end else begin
                     r_cnt     <= w_cnt_inc;
                     r_tx_data <= w_pay_next;
                  end
               end
            end
            ST_CRC: begin
               if (w_xfer) begin
                  if (r_cnt[1:0] == 2'd3) begin
                     r_state    <= ST_IDLE;
                     r_cnt      <= 6'd0;
                     r_tx_valid <= 1'b0;
                     r_tx_data  <= 8'h00;
                  end else begin
                     r_cnt     <= w_cnt_inc;
                     r_tx_data <= w_trl_next;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign tx_data   = r_tx_data;
   assign tx_valid  = r_tx_valid;
   assign req_ready = r_req_ready;
   assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_comm_tx_sched.sv
// ============================================================================
// tb_comm_tx_sched : scoreboard bench for comm_tx_sched (CRC and zero-trailer builds)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_comm_tx_sched;

   typedef struct {
      bit          sh;
      logic [7:0]  ty;
      logic [3:0]  w;
      logic [255:0] d;
   } desc_t;

   logic              comm_clk;
   logic              reset;
   logic [1:0]        req_valid;
   logic [1:0][7:0]   req_type;
   logic [1:0][3:0]   req_words;
   logic [1:0]        req_short;
   logic [1:0][255:0] req_data;
   logic              tx_ready;

   logic [1:0]        rdy1, rdy0;
   logic [7:0]        txd1, txd0;
   logic              txv1, txv0;
   logic              busy1, busy0;

   int                n_pass = 0;
   int                n_fail = 0;
   int                n_xfer = 0;
   int                busy_cnt = 0;
   int                exp_len = 0;
   int                tb_last = 1;
   bit                bp_en = 1'b0;
   logic [7:0]        q_crc[$];
   logic [7:0]        q_zero[$];
   logic [31:0]       crc_tab[256];

   comm_tx_sched #(.MAX_WORDS(8), .CRC_EN(1'b1)) u_dut_crc (
      .comm_clk  (comm_clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (rdy1),
      .req_type  (req_type),
      .req_words (req_words),
      .req_short (req_short),
      .req_data  (req_data),
      .tx_data   (txd1),
      .tx_valid  (txv1),
      .tx_ready  (tx_ready),
      .busy      (busy1)
   );

   comm_tx_sched #(.MAX_WORDS(8), .CRC_EN(1'b0)) u_dut_nocrc (
      .comm_clk  (comm_clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (rdy0),
      .req_type  (req_type),
      .req_words (req_words),
      .req_short (req_short),
      .req_data  (req_data),
      .tx_data   (txd0),
      .tx_valid  (txv0),
      .tx_ready  (tx_ready),
      .busy      (busy0)
   );

   initial begin
      comm_clk = 1'b0;
      forever #5 comm_clk = ~comm_clk;
   end

   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge comm_clk);
         #1;
         tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (ok) n_pass++;
      else begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] crc32_ref(input logic [7:0] b[$]);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (b[i]) c = crc_tab[c[7:0] ^ b[i]] ^ (c >> 8);
      return ~c;
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Reference packet: length, two zero bytes, type, payload LE, then CRC32 (or zeros)
   task automatic push_expected(input bit sh, input logic [7:0] ty, input logic [3:0] w, input logic [255:0] d);
      logic [7:0]  body[$];
      logic [31:0] c;
      int          n;
      if (sh) begin
         q_crc.push_back(ty);
         q_zero.push_back(ty);
         exp_len = 1;
         return;
      end
      n = (int'(w) > 8) ? 8 : int'(w);
      body.push_back(8'(8 + 4 * n));
      body.push_back(8'h00);
      body.push_back(8'h00);
      body.push_back(ty);
      for (int i = 0; i < 4 * n; i++) body.push_back(d[i*8 +: 8]);
      c = crc32_ref(body);
      foreach (body[i]) begin
         q_crc.push_back(body[i]);
         q_zero.push_back(body[i]);
      end
      for (int k = 0; k < 4; k++) begin
         q_crc.push_back(c[k*8 +: 8]);
         q_zero.push_back(8'h00);
      end
      exp_len = body.size() + 4;
   endtask

   task automatic drive(input int r, input desc_t x);
      req_short[r] = x.sh;
      req_type[r]  = x.ty;
      req_words[r] = x.w;
      req_data[r]  = x.d;
      req_valid[r] = 1'b1;
   endtask

   task automatic wait_grant(input int r);
      bit got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge comm_clk);
         #1;
         if (rdy1[r]) begin
            got = 1'b1;
            check(rdy0[r], "grant_nocrc", 32'(rdy0), 32'(rdy1));
         end
      end
      req_valid[r] = 1'b0;
      check(got, "grant_timeout", 32'(got), 32'd1);
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 4000 && !done; i++) begin
         @(negedge comm_clk);
         #1;
         if (!busy1 && !busy0 && q_crc.size() == 0 && q_zero.size() == 0) done = 1'b1;
      end
      check(done, "idle_timeout", 32'(q_crc.size()), 32'd0);
   endtask

   task automatic run_single(input int r, input desc_t x, input bit chk_len);
      busy_cnt = 0;
      push_expected(x.sh, x.ty, x.w, x.d);
      drive(r, x);
      wait_grant(r);
      wait_idle();
      tb_last = r;
      if (chk_len) check(busy_cnt == exp_len, "pkt_cycles", 32'(busy_cnt), 32'(exp_len));
   endtask

   task automatic do_reset();
      @(negedge comm_clk);
      reset = 1'b1;
      req_valid = 2'b00;
      q_crc.delete();
      q_zero.delete();
      @(negedge comm_clk);
      check(!txv1 && !txv0, "rst_tx_valid", 32'({txv1, txv0}), 32'd0);
      check(txd1 == 8'h00 && txd0 == 8'h00, "rst_tx_data", 32'({txd1, txd0}), 32'd0);
      check(rdy1 == 2'b00 && rdy0 == 2'b00, "rst_req_ready", 32'({rdy1, rdy0}), 32'd0);
      check(!busy1 && !busy0, "rst_busy", 32'({busy1, busy0}), 32'd0);
      @(negedge comm_clk);
      reset = 1'b0;
      tb_last = 1;
   endtask

   // Requester 0 re-requests the moment its first packet is accepted
   task automatic run_contention();
      desc_t a, b, c, x;
      desc_t p0[$], p1[$];
      int    win, stage;
      a = '{1'b0, 8'h01, 4'd1, rand256()};
      b = '{1'b0, 8'h02, 4'd2, rand256()};
      c = '{1'b0, 8'h03, 4'd1, rand256()};
      p0.push_back(a);
      p0.push_back(c);
      p1.push_back(b);
      while (p0.size() + p1.size() > 0) begin
         if (p0.size() > 0 && p1.size() > 0) win = (tb_last == 0) ? 1 : 0;
         else win = (p0.size() > 0) ? 0 : 1;
         x = (win == 0) ? p0.pop_front() : p1.pop_front();
         push_expected(x.sh, x.ty, x.w, x.d);
         tb_last = win;
      end
      drive(0, a);
      drive(1, b);
      stage = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge comm_clk);
         #1;
         if (rdy1[0]) begin
            if (stage == 0) begin
               drive(0, c);
               stage = 1;
            end else begin
               req_valid[0] = 1'b0;
               stage = 2;
            end
         end
         if (rdy1[1]) req_valid[1] = 1'b0;
         if (stage == 2 && !req_valid[1]) break;
      end
      check(stage == 2 && !req_valid[1], "contention_grants", 32'(stage), 32'd2);
      req_valid = 2'b00;
      wait_idle();
   endtask

   // Scoreboard monitor
   initial begin
      logic       prev_stall1, prev_stall0;
      logic [7:0] prev_d1, prev_d0, exp;
      logic [1:0] prev_rdy;
      prev_stall1 = 1'b0;
      prev_stall0 = 1'b0;
      prev_d1 = 8'h00;
      prev_d0 = 8'h00;
      prev_rdy = 2'b00;
      forever begin
         @(negedge comm_clk);
         if (reset) begin
            prev_stall1 = 1'b0;
            prev_stall0 = 1'b0;
            prev_rdy = 2'b00;
         end else begin
            if (busy1) busy_cnt++;
            if (prev_stall1) check(txv1 && txd1 == prev_d1, "hold_crc", 32'({txv1, txd1}), 32'({1'b1, prev_d1}));
            if (prev_stall0) check(txv0 && txd0 == prev_d0, "hold_nocrc", 32'({txv0, txd0}), 32'({1'b1, prev_d0}));
            if (txv1 && tx_ready) begin
               n_xfer++;
               if (q_crc.size() == 0) check(1'b0, "extra_byte_crc", 32'(txd1), 32'd0);
               else begin
                  exp = q_crc.pop_front();
                  check(txd1 == exp, "byte_crc", 32'(txd1), 32'(exp));
               end
            end
            if (txv0 && tx_ready) begin
               if (q_zero.size() == 0) check(1'b0, "extra_byte_nocrc", 32'(txd0), 32'd0);
               else begin
                  exp = q_zero.pop_front();
                  check(txd0 == exp, "byte_nocrc", 32'(txd0), 32'(exp));
               end
            end
            if (!busy1) check(!txv1, "valid_in_idle", 32'(txv1), 32'd0);
            for (int r = 0; r < 2; r++) begin
               if (rdy1[r]) check(!prev_rdy[r] && rdy1 != 2'b11, "ready_pulse", 32'({prev_rdy, rdy1}), 32'd0);
            end
            prev_stall1 = txv1 && !tx_ready;
            prev_stall0 = txv0 && !tx_ready;
            prev_d1 = txd1;
            prev_d0 = txd0;
            prev_rdy = rdy1;
         end
      end
   end

   initial begin
      desc_t       x;
      logic [255:0] d;
      logic [31:0] c;
      bit          ok;
      int          base;
      int          r;

      reset = 1'b1;
      req_valid = 2'b00;
      req_type = '0;
      req_words = '0;
      req_short = 2'b00;
      req_data = '0;
      for (int n = 0; n < 256; n++) begin
         c = 32'(n);
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         crc_tab[n] = c;
      end

      do_reset();

      run_single(0, '{1'b1, 8'h01, 4'd0, 256'd0}, 1'b1);
      run_single(0, '{1'b0, 8'h03, 4'd0, 256'd0}, 1'b1);
      d = '0;
      d[63:0] = {32'hDEADBEEF, 32'h13370D13};
      run_single(0, '{1'b0, 8'h00, 4'd2, d}, 1'b1);
      run_single(1, '{1'b0, 8'h02, 4'd8, rand256()}, 1'b1);
      run_single(1, '{1'b0, 8'h01, 4'd13, rand256()}, 1'b1);

      do_reset();
      run_contention();

      // Abort a full-size packet part way through, then restart cleanly
      x = '{1'b0, 8'h00, 4'd8, rand256()};
      push_expected(x.sh, x.ty, x.w, x.d);
      base = n_xfer;
      drive(0, x);
      wait_grant(0);
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge comm_clk);
         #1;
         if (n_xfer - base >= 20) ok = 1'b1;
      end
      check(ok, "abort_reach", 32'(n_xfer - base), 32'd20);
      reset = 1'b1;
      q_crc.delete();
      q_zero.delete();
      @(posedge comm_clk);
      @(negedge comm_clk);
      check(!txv1 && !txv0, "abort_tx_valid", 32'({txv1, txv0}), 32'd0);
      check(!busy1 && !busy0, "abort_busy", 32'({busy1, busy0}), 32'd0);
      @(negedge comm_clk);
      reset = 1'b0;
      tb_last = 1;
      run_single(1, '{1'b0, 8'h03, 4'd3, rand256()}, 1'b1);

      bp_en = 1'b1;
      for (int k = 0; k < 30; k++) begin
         r = $urandom_range(0, 1);
         x.sh = ($urandom_range(0, 3) == 0);
         x.ty = 8'($urandom_range(0, 3));
         x.w  = 4'($urandom_range(0, 15));
         x.d  = rand256();
         run_single(r, x, 1'b0);
      end
      bp_en = 1'b0;

      repeat (3) @(negedge comm_clk);
      $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
      $finish;
   end

endmodule

`default_nettype wire
